pc_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the MIPS54 core. It owns the fetch/execute/update cycle. It drives the PC register's load enable and next-PC value, handshakes with instruction memory and the execute datapath, and performs exception entry and ERET return. It sits between the control unit and the PC register.

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch / execute / update sequencer for the MIPS54 core.
// Drives the PC register load enable and next-PC value, handshakes with
// instruction memory and the execute datapath, and handles exception entry
// and ERET return. Every output is either a register or a decode of state.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] pc,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic [2:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx,
    input  logic [31:0] rs_val,
    input  logic [31:0] epc,
    input  logic        exc_req,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        epc_we,
    output logic [31:0] epc_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_JR     = 3'd3;
    localparam logic [2:0] SEL_ERET   = 3'd4;

    state_t      state_q, state_d;
    logic        exec_start_q;
    logic        exc_q;
    logic [31:0] pc_next_q;
    logic [31:0] epc_data_q;

    logic [31:0] p4;
    logic [31:0] target;
    logic        exc_now;

    // State register; reset drops the sequencer straight back to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: halt only matters in IDLE, handshakes only in their own state.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!halt)     state_d = FETCH;
            FETCH:   if (imem_ack)  state_d = EXEC;
            EXEC:    if (exec_done) state_d = UPDATE;
            UPDATE:                 state_d = FETCH;
            default:                state_d = IDLE;
        endcase
    end

    // Next-PC target and exception detection, consumed only on the exec_done cycle.
    always_comb begin
        p4      = pc + 32'd4;
        target  = p4;
        exc_now = exc_req;
        case (npc_sel)
            SEL_BRANCH: if (branch_taken) target = p4 + {{14{imm16[15]}}, imm16, 2'b00};
            SEL_JUMP:   target = {p4[31:28], jidx, 2'b00};
            SEL_JR: begin
                target = rs_val;
                if (rs_val[1:0] != 2'b00) exc_now = 1'b1;
            end
            SEL_ERET:   target = epc;
            default:    target = p4;
        endcase
        if (exc_now) target = EXC_VECTOR;
    end

    // Registered strobes and data: exec_start marks the first EXEC cycle,
    // pc_next / epc_data / exception flag capture on the exec_done cycle and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_start_q <= 1'b0;
            exc_q        <= 1'b0;
            pc_next_q    <= RESET_PC;
            epc_data_q   <= 32'd0;
        end else begin
            exec_start_q <= (state_q == FETCH) && imem_ack;
            if ((state_q == EXEC) && exec_done) begin
                exc_q     <= exc_now;
                pc_next_q <= target;
                if (exc_now) epc_data_q <= pc;
            end
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign exec_start = exec_start_q;
    assign pc_ena     = (state_q == UPDATE);
    assign epc_we     = (state_q == UPDATE) && exc_q;
    assign pc_next    = pc_next_q;
    assign epc_data   = epc_data_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed corner cases followed by
// randomized instruction streams checked against a behavioural next-PC model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [31:0] pc;
    logic        imem_req;
    logic        imem_ack;
    logic        exec_start;
    logic        exec_done;
    logic [2:0]  npc_sel;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic [31:0] epc;
    logic        exc_req;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        epc_we;
    logic [31:0] epc_data;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .exec_start   (exec_start),
        .exec_done    (exec_done),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jidx         (jidx),
        .rs_val       (rs_val),
        .epc          (epc),
        .exc_req      (exc_req),
        .pc_ena       (pc_ena),
        .pc_next      (pc_next),
        .epc_we       (epc_we),
        .epc_data     (epc_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC rules written as plain arithmetic.
    function automatic logic [31:0] model_target(
        input logic [31:0] cur_pc, input logic [2:0] sel, input logic taken,
        input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rs,
        input logic [31:0] e_pc, input logic exc, output logic exc_out);
        logic [31:0] p4;
        int          soff;
        p4      = cur_pc + 32'd4;
        soff    = int'($signed(off)) * 4;
        exc_out = exc || (sel == 3'd3 && (rs % 4) != 0);
        if (exc_out) return EXC_VECTOR;
        case (sel)
            3'd1:    return taken ? p4 + 32'(soff) : p4;
            3'd2:    return (p4 & 32'hF000_0000) | (32'(idx) * 32'd4);
            3'd3:    return rs;
            3'd4:    return e_pc;
            default: return p4;
        endcase
    endfunction

    task automatic check_strobes_low(input string tag);
        check({tag, ".imem_req"},   32'(imem_req),   32'd0);
        check({tag, ".exec_start"}, 32'(exec_start), 32'd0);
        check({tag, ".pc_ena"},     32'(pc_ena),     32'd0);
        check({tag, ".epc_we"},     32'(epc_we),     32'd0);
    endtask

    // One complete instruction; entered and left with the DUT in FETCH.
    task automatic run_instr(
        input string tag, input logic [31:0] cur_pc, input logic [2:0] sel,
        input logic taken, input logic [15:0] off, input logic [25:0] idx,
        input logic [31:0] rs, input logic [31:0] e_pc, input logic exc,
        input int ack_dly, input int done_dly, output logic [31:0] exp_pc);
        logic exp_exc;
        exp_pc = model_target(cur_pc, sel, taken, off, idx, rs, e_pc, exc, exp_exc);
        pc = cur_pc;
        check({tag, ".fetch_req"}, 32'(imem_req), 32'd1);
        for (int i = 0; i < ack_dly; i++) begin
            exec_done = 1'($urandom);   // stray done in FETCH must be ignored
            step();
            check({tag, ".fetch_wait_req"}, 32'(imem_req), 32'd1);
            check({tag, ".fetch_wait_ena"}, 32'(pc_ena),   32'd0);
        end
        exec_done = 1'b0;
        imem_ack  = 1'b1;
        step();
        imem_ack = 1'b0;
        check({tag, ".exec_start"}, 32'(exec_start), 32'd1);
        check({tag, ".exec_req"},   32'(imem_req),   32'd0);
        for (int i = 0; i < done_dly; i++) begin
            imem_ack = 1'($urandom);    // stray ack in EXEC must be ignored
            exc_req  = 1'($urandom);    // exc_req only counts with exec_done
            step();
            check({tag, ".exec_wait_start"}, 32'(exec_start), 32'd0);
            check({tag, ".exec_wait_ena"},   32'(pc_ena),     32'd0);
        end
        imem_ack     = 1'b0;
        npc_sel      = sel;
        branch_taken = taken;
        imm16        = off;
        jidx         = idx;
        rs_val       = rs;
        epc          = e_pc;
        exc_req      = exc;
        exec_done    = 1'b1;
        step();
        exec_done = 1'b0;
        exc_req   = 1'b0;
        check({tag, ".pc_ena"},  32'(pc_ena),  32'd1);
        check({tag, ".pc_next"}, pc_next,      exp_pc);
        check({tag, ".epc_we"},  32'(epc_we),  32'(exp_exc));
        if (exp_exc) check({tag, ".epc_data"}, epc_data, cur_pc);
        step();
        check({tag, ".refetch_req"}, 32'(imem_req), 32'd1);
        check({tag, ".refetch_ena"}, 32'(pc_ena),   32'd0);
        check({tag, ".refetch_we"},  32'(epc_we),   32'd0);
        check({tag, ".hold_next"},   pc_next,       exp_pc);
    endtask

    // Asynchronous reset from the current state, then halt hold and restart.
    task automatic reset_hold_restart(input string tag);
        rst = 1'b1;
        halt = 1'b1;
        #1;
        check_strobes_low({tag, ".async"});
        check({tag, ".async_next"}, pc_next, RESET_PC);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_strobes_low({tag, ".hold"});
            check({tag, ".hold_next"}, pc_next, RESET_PC);
        end
        halt = 1'b0;
        step();
        check({tag, ".restart_req"}, 32'(imem_req), 32'd1);
    endtask

    logic [31:0] nx;
    logic [31:0] cur;

    initial begin
        rst = 1'b1; halt = 1'b1; pc = RESET_PC;
        imem_ack = 1'b0; exec_done = 1'b0; npc_sel = 3'd0; branch_taken = 1'b0;
        imm16 = 16'd0; jidx = 26'd0; rs_val = 32'd0; epc = 32'd0; exc_req = 1'b0;
        #2;
        check_strobes_low("reset");
        check("reset.pc_next",  pc_next,  RESET_PC);
        check("reset.epc_data", epc_data, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_strobes_low("halt");
        end
        halt = 1'b0;
        check("halt.pre_req", 32'(imem_req), 32'd0);
        step();
        check("start.req", 32'(imem_req), 32'd1);

        // Sequential throughput and a slow memory.
        run_instr("seq0", 32'h0040_0000, 3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 0, 0, nx);
        check("seq0.value", nx, 32'h0040_0004);
        run_instr("seq1", 32'h0040_0000, 3'd6, 1'b1, 16'h7FFF, 26'h3FF_FFFF, 32'd1, 32'd8, 1'b0, 0, 0, nx);
        run_instr("seq_slow", 32'h0040_0000, 3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 3, 2, nx);

        // Branches, including address wrap.
        run_instr("br_taken", 32'h0040_0010, 3'd1, 1'b1, 16'hFFFE, 26'd0, 32'd0, 32'd0, 1'b0, 0, 0, nx);
        check("br_taken.value", nx, 32'h0040_000C);
        run_instr("br_not", 32'h0040_0010, 3'd1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 32'd0, 1'b0, 1, 0, nx);
        check("br_not.value", nx, 32'h0040_0014);
        run_instr("br_wrap", 32'hFFFF_FFFC, 3'd1, 1'b1, 16'h0000, 26'd0, 32'd0, 32'd0, 1'b0, 0, 1, nx);
        check("br_wrap.value", nx, 32'h0000_0000);

        // Jumps.
        run_instr("j", 32'h0040_001C, 3'd2, 1'b0, 16'd0, 26'h010_0008, 32'd0, 32'd0, 1'b0, 0, 0, nx);
        check("j.value", nx, 32'h0040_0020);
        run_instr("jr", 32'h0040_0024, 3'd3, 1'b0, 16'd0, 26'd0, 32'h0040_0100, 32'd0, 1'b0, 0, 0, nx);
        check("jr.value", nx, 32'h0040_0100);
        run_instr("jr_misalign", 32'h0040_0028, 3'd3, 1'b0, 16'd0, 26'd0, 32'h0040_0102, 32'd0, 1'b0, 0, 0, nx);
        check("jr_misalign.value", nx, EXC_VECTOR);

        // Exception beats eret, then a plain eret.
        run_instr("exc", 32'h0040_0030, 3'd4, 1'b0, 16'd0, 26'd0, 32'd0, 32'h0040_0040, 1'b1, 0, 2, nx);
        check("exc.value", nx, EXC_VECTOR);
        check("exc.epc_data_hold", epc_data, 32'h0040_0030);
        run_instr("eret", 32'h0040_0004, 3'd4, 1'b0, 16'd0, 26'd0, 32'd0, 32'h0040_0040, 1'b0, 0, 0, nx);
        check("eret.value", nx, 32'h0040_0040);

        // Reset mid-run from FETCH, hold, restart.
        reset_hold_restart("rst_fetch");

        // Reset while waiting in EXEC with exec_done arriving during reset.
        pc = 32'h0040_0000;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("rst_exec.start", 32'(exec_start), 32'd1);
        step();
        rst = 1'b1;
        #1;
        check_strobes_low("rst_exec.async");
        exec_done = 1'b1;
        exc_req   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_strobes_low("rst_exec.during");
            check("rst_exec.pc_next", pc_next, RESET_PC);
        end
        exec_done = 1'b0;
        exc_req   = 1'b0;
        rst = 1'b0;
        check("rst_exec.release_idle", 32'(imem_req), 32'd0);
        step();
        check("rst_exec.restart_req", 32'(imem_req), 32'd1);
        check("rst_exec.restart_ena", 32'(pc_ena),   32'd0);

        // Randomized stream; the bench plays the PC register.
        cur = RESET_PC;
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  sel;
            logic [31:0] rs;
            sel = 3'($urandom_range(0, 7));
            rs  = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) cur = $urandom;
            run_instr($sformatf("rand%0d", n), cur, sel, 1'($urandom), 16'($urandom),
                      26'($urandom), rs, $urandom, ($urandom_range(0, 9) == 0),
                      $urandom_range(0, 3), $urandom_range(0, 3), nx);
            cur = nx;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
